instr_mem_encoder: RTL and testbench

// - Encoder side of the main-control opcode decode: builds 32-bit MIPS words (R, lw, sw, beq, addi, bne, j)

---
 rtl/instr_mem_encoder.sv | 117 +++++++++++
 tb/tb_instr_mem_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_encoder.sv
// Builds 32-bit MIPS instruction words from field-level requests and streams them
// into instruction memory through a registered write port behind a LOAD/DONE pointer FSM.
//
// state  | meaning
// S_IDLE | after reset, no load started, requests ignored
// S_LOAD | accepting requests, one imem write per legal transfer
// S_DONE | load ended by stop or by the final word, requests ignored until start
module instr_mem_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic        w_xfer;
    logic        w_legal;
    logic        w_last;
    logic [31:0] w_enc;

    assign in_ready = (r_state == S_LOAD);
    assign w_xfer   = in_valid & in_ready;
    assign w_legal  = (op_sel != 3'd7);
    assign w_last   = (r_count == LAST_CNT);

    always_comb begin
        w_enc = '0;
        case (op_sel)
            3'd0:    w_enc = {6'b000000, rs, rt, rd, shamt, funct};
            3'd1:    w_enc = {6'b100011, rs, rt, imm};
            3'd2:    w_enc = {6'b101011, rs, rt, imm};
            3'd3:    w_enc = {6'b000100, rs, rt, imm};
            3'd4:    w_enc = {6'b001000, rs, rt, imm};
            3'd5:    w_enc = {6'b000101, rs, rt, imm};
            3'd6:    w_enc = {6'b000010, target};
            default: w_enc = '0;
        endcase
    end

    // start has priority over any same-cycle stop or transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wptr  <= BASE;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (start) begin
                r_state <= S_LOAD;
                r_wptr  <= BASE;
                r_count <= '0;
            end else if (w_xfer) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_wptr;
                    r_wdata <= w_enc;
                    r_count <= r_count + (ADDR_W+1)'(1);
                    // the pointer parks on the final slot instead of running past it
                    if (w_last) r_state <= S_DONE;
                    else        r_wptr  <= r_wptr + ADDR_W'(1);
                end else begin
                    r_err <= 1'b1;
                end
                if (stop) r_state <= S_DONE;
            end else if (stop && (r_state == S_LOAD)) begin
                r_state <= S_DONE;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

endmodule

// File: tb/tb_instr_mem_encoder.sv
// Bench for instr_mem_encoder: directed encoding/handshake scenarios plus a random run
// compared against a word-level load model, on a full-size and a DEPTH=4 instance.
module tb_instr_mem_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, in_valid;
    logic [2:0]  op_sel;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    logic        a_ready, a_we, a_done, a_err;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;
    logic        b_ready, b_we, b_done, b_err;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic [8:0]  b_count;

    int errors = 0;
    int checks = 0;

    instr_mem_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(a_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .count(a_count), .done(a_done), .err(a_err));

    instr_mem_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(b_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm), .target(target),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .count(b_count), .done(b_done), .err(b_err));

    // reference: load is a list of words at consecutive addresses from base
    int m_st[2];   // 0 idle, 1 loading, 2 finished
    int m_cnt[2];
    int m_dep[2];

    function automatic logic [31:0] ref_enc(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t,
                                            input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                            input logic [15:0] im, input logic [25:0] tg);
        logic [31:0] w;
        w = 32'h0;
        case (op)
            3'd0: w = (32'h00 << 26) | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
            3'd1: w = (32'h23 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            3'd2: w = (32'h2B << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            3'd3: w = (32'h04 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            3'd4: w = (32'h08 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            3'd5: w = (32'h05 << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
            3'd6: w = (32'h02 << 26) | 32'(tg);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start = 0; stop = 0; in_valid = 0; op_sel = 0;
        rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
    endtask

    task automatic set_req(input logic [2:0] op, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        in_valid = 1; op_sel = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        tick(); tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", a_we); end
        checks++; if (a_addr !== 8'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", a_addr); end
        checks++; if (a_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %0h want 0", a_wdata); end
        checks++; if (a_count !== 9'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", a_done); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", a_err); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", a_ready); end
        reset = 0;
        set_req(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL idle_valid_we: got %0b want 0", a_we); end
        op_sel = 3'd7;
        tick();
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL idle_valid_err: got %0b want 0", a_err); end
        checks++; if (a_count !== 9'h0) begin errors++; $display("FAIL idle_valid_count: got %0d want 0", a_count); end
        idle_inputs();
    endtask

    task automatic test_encodings;
        logic [2:0]  t_op[7]  = '{3'd1, 3'd0, 3'd6, 3'd3, 3'd2, 3'd4, 3'd5};
        logic [4:0]  t_rs[7]  = '{5'd2, 5'd1, 5'd31, 5'd4, 5'd1, 5'd0, 5'd1};
        logic [4:0]  t_rt[7]  = '{5'd3, 5'd2, 5'd31, 5'd5, 5'd2, 5'd8, 5'd2};
        logic [4:0]  t_rd[7]  = '{5'd7, 5'd3, 5'd9, 5'd7, 5'd7, 5'd7, 5'd7};
        logic [4:0]  t_sh[7]  = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5};
        logic [5:0]  t_fn[7]  = '{6'h3F, 6'h20, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
        logic [15:0] t_im[7]  = '{16'h0010, 16'hAAAA, 16'h1234, 16'hFFFF, 16'h0004, 16'h0005, 16'hFFFE};
        logic [25:0] t_tg[7]  = '{26'h2AAAAAA, 26'h2AAAAAA, 26'h0000100, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA, 26'h2AAAAAA};
        logic [31:0] t_exp[7] = '{32'h8C430010, 32'h00221820, 32'h08000100, 32'h1085FFFF,
                                  32'hAC220004, 32'h20080005, 32'h1422FFFE};
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %0b want 1", a_ready); end
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL start_count: got %0d want 0", a_count); end
        for (int i = 0; i < 7; i++) begin
            set_req(t_op[i], t_rs[i], t_rt[i], t_rd[i], t_sh[i], t_fn[i], t_im[i], t_tg[i]);
            tick();
            checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL enc%0d_we: got %0b want 1", i, a_we); end
            checks++; if (a_addr !== 8'(i)) begin errors++; $display("FAIL enc%0d_addr: got %0d want %0d", i, a_addr, i); end
            checks++; if (a_wdata !== t_exp[i]) begin errors++; $display("FAIL enc%0d_wdata: got %08h want %08h", i, a_wdata, t_exp[i]); end
            checks++; if (a_count !== 9'(i + 1)) begin errors++; $display("FAIL enc%0d_count: got %0d want %0d", i, a_count, i + 1); end
        end
        idle_inputs();
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL enc_gap_we: got %0b want 0", a_we); end
    endtask

    task automatic test_illegal;
        set_req(3'd7, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h6666, 26'd7);
        tick();
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %0b want 1", a_err); end
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL illegal_we: got %0b want 0", a_we); end
        checks++; if (a_count !== 9'd7) begin errors++; $display("FAIL illegal_count: got %0d want 7", a_count); end
        set_req(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        tick();
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse: got %0b want 0", a_err); end
        checks++; if (a_addr !== 8'd7) begin errors++; $display("FAIL illegal_next_addr: got %0d want 7", a_addr); end
        idle_inputs();
    endtask

    task automatic test_start_stop;
        idle_inputs();
        start = 1; stop = 1;
        tick();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL startstop_ready: got %0b want 1", a_ready); end
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL startstop_count: got %0d want 0", a_count); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL startstop_done: got %0b want 0", a_done); end
        start = 0;
        tick();
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL stop_done: got %0b want 1", a_done); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %0b want 0", a_ready); end
        stop = 0;
        set_req(3'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL done_valid_we: got %0b want 0", a_we); end
        idle_inputs();
    endtask

    task automatic test_stop_with_xfer;
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        set_req(3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0);
        stop = 1;
        tick();
        checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL stopx_we: got %0b want 1", a_we); end
        checks++; if (a_wdata !== 32'hAC220004) begin errors++; $display("FAIL stopx_wdata: got %08h want ac220004", a_wdata); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL stopx_done: got %0b want 1", a_done); end
        checks++; if (a_count !== 9'd1) begin errors++; $display("FAIL stopx_count: got %0d want 1", a_count); end
        idle_inputs();
    endtask

    task automatic test_full;
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(3'd4, 5'(i), 5'd9, 5'd0, 5'd0, 6'd0, 16'(i + 1), 26'd0);
            checks++; if (b_ready !== (i < 4)) begin errors++; $display("FAIL full%0d_ready: got %0b want %0b", i, b_ready, i < 4); end
            tick();
            checks++; if (b_we !== (i < 4)) begin errors++; $display("FAIL full%0d_we: got %0b want %0b", i, b_we, i < 4); end
            if (i < 4) begin
                checks++; if (b_addr !== 8'(i)) begin errors++; $display("FAIL full%0d_addr: got %0d want %0d", i, b_addr, i); end
            end
        end
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b want 1", b_done); end
        checks++; if (b_count !== 9'd4) begin errors++; $display("FAIL full_count: got %0d want 4", b_count); end
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", b_ready); end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        start = 1;
        tick();
        start = 0;
        set_req(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        tick();
        checks++; if (a_we !== 1'b1) begin errors++; $display("FAIL rmid_pre_we: got %0b want 1", a_we); end
        reset = 1;
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %0b want 0", a_we); end
        checks++; if (a_count !== 9'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", a_count); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %0b want 0", a_ready); end
        reset = 0;
        tick();
        checks++; if (a_we !== 1'b0) begin errors++; $display("FAIL rmid_after_we: got %0b want 0", a_we); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rmid_after_ready: got %0b want 0", a_ready); end
        idle_inputs();
    endtask

    task automatic test_random;
        logic        exp_we[2], exp_err[2];
        logic [7:0]  exp_addr[2];
        logic [31:0] exp_data[2];
        logic        obs_rdy, obs_we, obs_err, obs_done;
        logic [7:0]  obs_addr;
        logic [31:0] obs_data;
        logic [8:0]  obs_cnt;
        int r;
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
        for (int d = 0; d < 2; d++) begin m_st[d] = 0; m_cnt[d] = 0; end
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            start    = (r < 4);
            stop     = (r >= 4 && r < 7);
            in_valid = start ? 1'b0 : ($urandom_range(0, 3) != 0);
            op_sel   = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); shamt = 5'($urandom);
            funct = 6'($urandom); imm = 16'($urandom); target = 26'($urandom);
            for (int d = 0; d < 2; d++) begin
                obs_rdy = (d == 0) ? a_ready : b_ready;
                checks++; if (obs_rdy !== (m_st[d] == 1)) begin errors++; $display("FAIL rnd_ready d%0d c%0d: got %0b want %0b", d, c, obs_rdy, m_st[d] == 1); end
                exp_we[d] = 0; exp_err[d] = 0; exp_addr[d] = 0; exp_data[d] = 0;
                if (start) begin
                    m_st[d] = 1; m_cnt[d] = 0;
                end else if (m_st[d] == 1 && in_valid) begin
                    if (op_sel != 3'd7) begin
                        exp_we[d] = 1;
                        exp_addr[d] = 8'(m_cnt[d] % 256);
                        exp_data[d] = ref_enc(op_sel, rs, rt, rd, shamt, funct, imm, target);
                        m_cnt[d]++;
                        if (m_cnt[d] == m_dep[d]) m_st[d] = 2;
                    end else begin
                        exp_err[d] = 1;
                    end
                    if (stop) m_st[d] = 2;
                end else if (m_st[d] == 1 && stop) begin
                    m_st[d] = 2;
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                obs_we   = (d == 0) ? a_we    : b_we;
                obs_err  = (d == 0) ? a_err   : b_err;
                obs_done = (d == 0) ? a_done  : b_done;
                obs_addr = (d == 0) ? a_addr  : b_addr;
                obs_data = (d == 0) ? a_wdata : b_wdata;
                obs_cnt  = (d == 0) ? a_count : b_count;
                checks++; if (obs_we !== exp_we[d]) begin errors++; $display("FAIL rnd_we d%0d c%0d: got %0b want %0b", d, c, obs_we, exp_we[d]); end
                checks++; if (obs_err !== exp_err[d]) begin errors++; $display("FAIL rnd_err d%0d c%0d: got %0b want %0b", d, c, obs_err, exp_err[d]); end
                checks++; if (obs_done !== (m_st[d] == 2)) begin errors++; $display("FAIL rnd_done d%0d c%0d: got %0b want %0b", d, c, obs_done, m_st[d] == 2); end
                checks++; if (obs_cnt !== 9'(m_cnt[d])) begin errors++; $display("FAIL rnd_count d%0d c%0d: got %0d want %0d", d, c, obs_cnt, m_cnt[d]); end
                if (exp_we[d]) begin
                    checks++; if (obs_addr !== exp_addr[d]) begin errors++; $display("FAIL rnd_addr d%0d c%0d: got %0d want %0d", d, c, obs_addr, exp_addr[d]); end
                    checks++; if (obs_data !== exp_data[d]) begin errors++; $display("FAIL rnd_wdata d%0d c%0d: got %08h want %08h", d, c, obs_data, exp_data[d]); end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_dep[0] = 256;
        m_dep[1] = 4;
        reset = 1;
        idle_inputs();
        test_reset();
        test_encodings();
        test_illegal();
        test_start_stop();
        test_stop_with_xfer();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
